// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } seq_det_state_t;

    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // A length of zero or anything wider than the pattern means "use the full pattern".
    function automatic int unsigned clamp_len(input int unsigned len_in, input int unsigned pat_w);
        return ((len_in == 0) || (len_in > pat_w)) ? pat_w : len_in;
    endfunction

endpackage

// File: rtl/seq_det_shift_reg.sv
// History shift register: newest bit enters at bit 0; clear beats shift.
module seq_det_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         d,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt
);

    logic [W-1:0] q_q, q_d;

    // nxt is the would-be contents after a shift, so the compare can look one bit ahead.
    assign nxt = {q_q[W-2:0], d};
    assign q   = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-loadable serial pattern detector with overlap control.
// Optional saturating match counter enabled by SEQ_DET_MATCH_CNT_EN.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_0101,
    parameter int               RST_LEN = 3,
    parameter bit               RST_OVL = 1'b1,
    parameter int               CNT_W   = 16,
    localparam int              LEN_W   = calc_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             i,
    input  logic             ld,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             ovl_in,
    output logic             out,
    output logic             armed
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, PAT_W));

    seq_det_state_t   state_q, state_d;
    logic [LEN_W-1:0] fill_q, fill_d, fill_inc;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic             out_q, out_d;
    logic [PAT_W-1:0] hist_q, hist_nxt, mask;
    logic             match;

    seq_det_shift_reg #(
        .W(PAT_W)
    ) u_hist (
        .clk (clk),
        .rst (rst),
        .clr (ld),
        .en  (en),
        .d   (i),
        .q   (hist_q),
        .nxt (hist_nxt)
    );

    always_comb begin
        mask     = ~({PAT_W{1'b1}} << len_q);
        fill_inc = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
        match    = en && (fill_inc == len_q) && ((hist_nxt & mask) == (pat_q & mask));

        state_d = state_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        out_d   = 1'b0;

        if (ld) begin
            pat_d   = pat_in;
            len_d   = LEN_W'(clamp_len(32'(len_in), PAT_W));
            ovl_d   = ovl_in;
            fill_d  = '0;
            state_d = FILL;
        end else if (en) begin
            fill_d  = fill_inc;
            state_d = (fill_inc == len_q) ? ARMED : FILL;
            out_d   = match;
            // Non-overlap: hist is kept but must be fully refilled before the next compare.
            if (match && !ovl_q) begin
                fill_d  = '0;
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            pat_q   <= RST_PAT;
            len_q   <= RST_LEN_C;
            ovl_q   <= RST_OVL;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            out_q   <= out_d;
        end
    end

    assign out   = out_q;
    assign armed = (state_q == ARMED);

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = '0;
        end else if (out_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic [CNT_W-1:0] cnt_unused;
    assign cnt_unused = '0;
`endif

endmodule
